adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Sequences one ADC capture into the ADC sample FIFO. On a host start request it pulses the FIFO reset and waits out the FIFO recovery time. It then gates the FIFO write enable for exactly N accepted samples and reports done, busy and overflow status to the host wire-out endpoint. It sits between the host wire-in/wire-out endpoints and the FIFO write side, replacing the free-running wr_en=1.

Parameters:
CNT_W, 16, width of sample count and programmed length
RST_CYCLES, 4, cycles fifo_rst is held high (>=1)
RST_RECOVER, 8, cycles after fifo_rst falls before the first write (>=1)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start request from host
abort  in  1  one-cycle abort request
num_samples  in  CNT_W  capture length; latched on an accepted start
sample_valid  in  1  a new ADC code is present this cycle
fifo_full  in  1  FIFO full flag
fifo_rst  out  1  reset to FIFO (registered)
fifo_wr_en  out  1  FIFO write enable (combinational)
busy  out  1  high in RST, RECOVER and CAPTURE
done  out  1  high in DONE
overflow  out  1  sticky: a valid sample was dropped because the FIFO was full
samples_written  out  CNT_W  count of accepted writes in the current capture
state_o  out  3  current state encoding, for debug wire-out

Behaviour:
- States: IDLE=0, RST=1, RECOVER=2, CAPTURE=3, DONE=4. Registered, one-hot-free binary.
- Reset values: state IDLE; fifo_rst 0; busy 0; done 0; overflow 0; samples_written 0; internal length register 0; delay counter 0.
- IDLE or DONE, start=1: latch num_samples, clear overflow and samples_written, load delay counter, go to RST next cycle.
- start in RST, RECOVER or CAPTURE: ignored, with no effect on any register.
- RST: fifo_rst=1 for exactly RST_CYCLES cycles, then enter RECOVER. fifo_rst is registered, so it rises on the first RST cycle.
- RECOVER: fifo_rst=0 for RST_RECOVER cycles. Then:
  - latched length 0: go to DONE;
  - otherwise: go to CAPTURE.
- CAPTURE: fifo_wr_en = sample_valid & ~fifo_full & ~abort. Each write increments samples_written.
  - The write that makes samples_written equal to the latched length moves to DONE on the next cycle. No further wr_en.
  - sample_valid & fifo_full: sample dropped, overflow<=1, count unchanged, capture continues.
- DONE: done=1 and held until an accepted start or rst. samples_written holds its final value.
- abort (any state except IDLE): next state IDLE, fifo_rst<=0, done<=0. overflow and samples_written are held for host readback. abort has priority over start in the same cycle.
- fifo_wr_en is 0 in every state other than CAPTURE.
- Counter arithmetic is unsigned CNT_W and cannot wrap, because the length is at most 2^CNT_W-1.
- rst mid-operation: everything returns to reset values on the next edge, and fifo_rst drops immediately at that edge.

Optional Feature:
ADC_CAPTURE_DECIMATE_EN
- Defined: adds input decim[7:0], sampled at start. In CAPTURE only every (decim+1)-th valid sample is a write candidate.
  - The decimation counter is cleared on CAPTURE entry, so the first valid sample is a candidate.
  - Decimation-skipped samples never set overflow.
  - decim=0 is identical to undefined behaviour.
- Undefined: no decim port; every valid sample is a write candidate.

Decomposition:
- Package adc_capture_pkg: state encoding localparams (ST_IDLE..ST_DONE), STATE_W=3, default CNT_W/RST_CYCLES/RST_RECOVER.
- One sub-module: adc_cap_delay_cnt, a loadable down-counter with a zero flag, used for both the RST and RECOVER intervals.
- The FSM stays in adc_capture_ctrl.

Test Plan:
- rst, then start with num_samples=5 and sample_valid=1 constant:
  - fifo_rst high 4 cycles, then low 8 cycles;
  - then fifo_wr_en high exactly 5 cycles;
  - done=1, samples_written=5, busy=0.
- num_samples=0, start: RST(4) then RECOVER(8), then DONE; fifo_wr_en never asserted.
- num_samples=10, fifo_full forced high for 3 valid cycles mid-capture:
  - overflow=1, those 3 samples dropped;
  - capture still completes with samples_written=10.
- abort in CAPTURE after 3 writes: next cycle state IDLE, fifo_wr_en=0, samples_written=3, done=0. A following start clears samples_written to 0.
- start asserted during RECOVER and during CAPTURE: no state or length change. rst asserted during CAPTURE: all outputs at reset values on the next edge.
- ADC_CAPTURE_DECIMATE_EN, decim=2, num_samples=4, sample_valid every cycle: writes on CAPTURE cycles 0, 3, 6 and 9, then DONE.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared encodings and defaults for the ADC capture controller.
package adc_capture_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RST     = 3'd1;
  localparam logic [STATE_W-1:0] ST_RECOVER = 3'd2;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_RST     = ST_RST,
    S_RECOVER = ST_RECOVER,
    S_CAPTURE = ST_CAPTURE,
    S_DONE    = ST_DONE
  } state_t;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_RST_CYCLES  = 4;
  localparam int unsigned DEF_RST_RECOVER = 8;

  // Larger of two interval lengths, used to size the shared delay counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_cap_delay_cnt.sv
// Loadable down-counter with a zero flag; times the FIFO reset and recovery intervals.
module adc_cap_delay_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Sequences one ADC capture: FIFO reset, recovery wait, then N gated writes.
// Optional decimation enabled by defining ADC_CAPTURE_DECIMATE_EN.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned RST_RECOVER = DEF_RST_RECOVER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_samples,
`ifdef ADC_CAPTURE_DECIMATE_EN
  input  logic [7:0]         decim,
`endif
  input  logic               sample_valid,
  input  logic               fifo_full,
  output logic               fifo_rst,
  output logic               fifo_wr_en,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [CNT_W-1:0]   samples_written,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned DLY_W = $clog2(max_u(RST_CYCLES, RST_RECOVER) + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             fifo_rst_q, fifo_rst_d;
  logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic             accept_c, cand_c, wr_c;
  logic             dly_load, dly_dec, dly_zero_c;
  logic [DLY_W-1:0] dly_val;

  adc_cap_delay_cnt #(.W(DLY_W)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero_c   (dly_zero_c)
  );

`ifdef ADC_CAPTURE_DECIMATE_EN
  logic [7:0] decim_q, decim_d, dcnt_q, dcnt_d;

  // Decimation phase: restarts at zero on every CAPTURE entry, advances on each valid sample.
  always_comb begin
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    if (accept_c) decim_d = decim;
    if (state_q != S_CAPTURE) begin
      dcnt_d = '0;
    end else if (sample_valid) begin
      dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 8'd1;
    end
  end

  // Decimation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      decim_q <= '0;
      dcnt_q  <= '0;
    end else begin
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign cand_c = (dcnt_q == '0);
`else
  assign cand_c = 1'b1;
`endif

  assign accept_c = start & ~abort & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign wr_c     = (state_q == S_CAPTURE) & sample_valid & ~fifo_full & ~abort & cand_c;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    dly_load = 1'b0;
    dly_dec  = 1'b0;
    dly_val  = '0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_c) begin
            len_d    = num_samples;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            dly_load = 1'b1;
            dly_val  = DLY_W'(RST_CYCLES - 1);
            state_d  = S_RST;
          end
        end
        S_RST: begin
          if (dly_zero_c) begin
            dly_load = 1'b1;
            dly_val  = DLY_W'(RST_RECOVER - 1);
            state_d  = S_RECOVER;
          end else begin
            dly_dec = 1'b1;
          end
        end
        S_RECOVER: begin
          if (dly_zero_c) begin
            state_d = (len_q == '0) ? S_DONE : S_CAPTURE;
          end else begin
            dly_dec = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (sample_valid && fifo_full && cand_c) ovf_d = 1'b1;
          if (wr_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == len_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    fifo_rst_d = (state_d == S_RST);
    busy_d     = (state_d == S_RST) | (state_d == S_RECOVER) | (state_d == S_CAPTURE);
    done_d     = (state_d == S_DONE);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      fifo_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      fifo_rst_q <= fifo_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fifo_rst        = fifo_rst_q;
  assign fifo_wr_en      = wr_c;
  assign busy            = busy_q;
  assign done            = done_q;
  assign overflow        = ovf_q;
  assign samples_written = cnt_q;
  assign state_o         = STATE_W'(state_q);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized and directed bench for adc_capture_ctrl against a timeline-based reference model.
// Covers the decimation port when ADC_CAPTURE_DECIMATE_EN is defined.
module tb_adc_capture_ctrl;

  localparam int RC = 4;
  localparam int RR = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, sample_valid, fifo_full;
  logic [15:0] num_samples;
`ifdef ADC_CAPTURE_DECIMATE_EN
  logic [7:0]  decim;
`endif
  logic        fifo_rst, fifo_wr_en, busy, done, overflow;
  logic [15:0] samples_written;
  logic [2:0]  state_o;

  adc_capture_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .num_samples     (num_samples),
`ifdef ADC_CAPTURE_DECIMATE_EN
    .decim           (decim),
`endif
    .sample_valid    (sample_valid),
    .fifo_full       (fifo_full),
    .fifo_rst        (fifo_rst),
    .fifo_wr_en      (fifo_wr_en),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .samples_written (samples_written),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: time since the accepted start decides the phase.
  bit m_active, m_done, m_ovf;
  int m_el, m_len, m_wr, m_vc, m_dec;
  int wr_seen, rst_seen;
  bit last_wr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_state();
    if (m_active) begin
      if (m_el <= RC)      return 1;
      if (m_el <= RC + RR) return 2;
      return 3;
    end
    return m_done ? 4 : 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_ovf = 0;
    m_el = 0; m_len = 0; m_wr = 0; m_vc = 0; m_dec = 0;
  endtask

  // One clock: check registered outputs, drive inputs, check wr_en, advance model.
  task automatic step(input bit r, input bit s, input bit a, input int n,
                      input bit v, input bit f, input int dm);
    int st;
    bit cand, ew;
    @(negedge clk);
    st = exp_state();
    check_eq("state_o",         32'(state_o),         32'(st));
    check_eq("fifo_rst",        32'(fifo_rst),        32'(st == 1));
    check_eq("busy",            32'(busy),            32'(st >= 1 && st <= 3));
    check_eq("done",            32'(done),            32'(m_done && !m_active));
    check_eq("overflow",        32'(overflow),        32'(m_ovf));
    check_eq("samples_written", 32'(samples_written), 32'(m_wr));
    if (fifo_rst) rst_seen++;
    rst = r; start = s; abort = a; num_samples = 16'(n);
    sample_valid = v; fifo_full = f;
`ifdef ADC_CAPTURE_DECIMATE_EN
    decim = 8'(dm);
`endif
    #1;
    cand = (m_vc % (m_dec + 1)) == 0;
    ew   = (st == 3) && v && !f && !a && cand;
    check_eq("fifo_wr_en", 32'(fifo_wr_en), 32'(ew));
    last_wr = fifo_wr_en;
    if (fifo_wr_en) wr_seen++;
    if (r) begin
      model_reset();
    end else if (a && st != 0) begin
      m_active = 0; m_done = 0;
    end else if (s && !a && (st == 0 || st == 4)) begin
      m_active = 1; m_done = 0; m_el = 1; m_len = n;
      m_wr = 0; m_ovf = 0; m_vc = 0;
`ifdef ADC_CAPTURE_DECIMATE_EN
      m_dec = dm;
`else
      m_dec = 0;
`endif
    end else if (m_active) begin
      if (st == 3) begin
        if (v) begin
          if (cand && f) m_ovf = 1;
          m_vc++;
        end
        if (ew) begin
          m_wr++;
          if (m_wr == m_len) begin m_active = 0; m_done = 1; end
        end
      end else begin
        m_el++;
        if (m_el > RC + RR && m_len == 0) begin m_active = 0; m_done = 1; end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    int mask;
    rst = 1; start = 0; abort = 0; num_samples = '0; sample_valid = 0; fifo_full = 0;
`ifdef ADC_CAPTURE_DECIMATE_EN
    decim = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);

    // Basic capture of 5 with continuous valid samples.
    step(1, 0, 0, 0, 0, 0, 0);
    wr_seen = 0; rst_seen = 0;
    step(0, 1, 0, 5, 1, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 0, 1, 0, 0);
    #1;
    check_eq("t1_writes", 32'(wr_seen), 32'd5);
    check_eq("t1_rst_cycles", 32'(rst_seen), 32'(RC));
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_written", 32'(samples_written), 32'd5);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // Zero-length capture.
    wr_seen = 0;
    step(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, 0, 0);
    #1;
    check_eq("t2_writes", 32'(wr_seen), 32'd0);
    check_eq("t2_state", 32'(state_o), 32'd4);

    // Capture of 10 with FIFO full for 3 valid cycles.
    wr_seen = 0;
    for (int i = 0; i < 30; i++)
      step(0, i == 0, 0, 10, 1, (i >= 15 && i <= 17), 0);
    #1;
    check_eq("t3_overflow", 32'(overflow), 32'd1);
    check_eq("t3_written", 32'(samples_written), 32'd10);
    check_eq("t3_writes", 32'(wr_seen), 32'd10);
    check_eq("t3_done", 32'(done), 32'd1);

    // Abort after 3 writes, then restart.
    for (int i = 0; i < 17; i++)
      step(0, i == 0, i == 16, 8, 1, 0, 0);
    #1;
    check_eq("t4_state", 32'(state_o), 32'd0);
    check_eq("t4_written", 32'(samples_written), 32'd3);
    check_eq("t4_done", 32'(done), 32'd0);
    step(0, 1, 0, 4, 0, 0, 0);
    #1;
    check_eq("t4_restart_written", 32'(samples_written), 32'd0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0, 0);

    // Start ignored in RECOVER and CAPTURE; then rst mid-capture.
    wr_seen = 0;
    for (int i = 0; i < 26; i++) begin
      if (i == 7)       step(0, 1, 0, 2, 1, 0, 0);
      else if (i == 14) step(0, 1, 0, 1, 1, 0, 0);
      else              step(0, i == 0, 0, 6, 1, 0, 0);
    end
    #1;
    check_eq("t5_writes", 32'(wr_seen), 32'd6);
    for (int i = 0; i < 16; i++) step(0, i == 0, 0, 9, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    #1;
    check_eq("t5_rst_state", 32'(state_o), 32'd0);
    check_eq("t5_rst_written", 32'(samples_written), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);

`ifdef ADC_CAPTURE_DECIMATE_EN
    // decim=2, length 4: writes on capture cycles 0,3,6,9.
    mask = 0; wr_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, i == 0, 0, 4, 1, 0, 2);
      if (last_wr && i >= 13) mask |= (1 << (i - 13));
    end
    #1;
    check_eq("t6_positions", 32'(mask), 32'h249);
    check_eq("t6_done", 32'(done), 32'd1);
`else
    mask = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      bit r, s, a;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 19) == 0);
      a = !s && ($urandom_range(0, 149) == 0);
      step(r, s, a, int'($urandom_range(0, 12)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 6) == 0),
           int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
